// File: rtl/rr_arb_4_way.sv
// Four-way round-robin arbiter with stall timeout and a shared payload mux.
// A stalled grant is aborted after TIMEOUT_CYCLES so one requester cannot hog the bus.
module rr_arb_4_way #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [3:0]            req_in,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [DATA_WIDTH-1:0] c_in,
  input  logic [DATA_WIDTH-1:0] d_in,
  input  logic                  ready_in,
  output logic [3:0]            gnt_out,
  output logic [1:0]            sel_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  timeout_out
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  localparam logic [7:0] STALL_MAX = 8'(TIMEOUT_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic [1:0] r_last;
  logic [7:0] r_stall;
  logic       r_valid;
  logic       r_tmo;
  logic       r_armed;

  logic       w_busy;
  logic       w_cur_req;
  logic       w_xfer;
  logic       w_wdraw;
  logic       w_abort;
  logic       w_done;
  logic       w_any;
  logic [1:0] w_last_nxt;
  logic [1:0] w_pick;

  // Scan last+1 .. last+4; the lowest offset with a request wins.
  function automatic logic [1:0] f_pick(
    input logic [3:0] req,
    input logic [1:0] last
  );
    logic [1:0] idx;
    f_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) f_pick = idx;
    end
  endfunction

  always_comb begin
    w_busy     = (r_state == S_GRANT);
    w_cur_req  = req_in[r_sel];
    w_xfer     = w_busy && w_cur_req && ready_in;
    w_wdraw    = w_busy && !w_cur_req;
    w_abort    = w_busy && w_cur_req && !ready_in
                 && (r_stall == STALL_MAX);
    w_done     = w_xfer || w_wdraw || w_abort;
    w_any      = |req_in;
    w_last_nxt = (w_xfer || w_abort) ? r_sel : r_last;
    w_pick     = f_pick(req_in, w_last_nxt);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_last  <= 2'd3;
      r_stall <= 8'd0;
      r_valid <= 1'b0;
      r_tmo   <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      // First edge after release only arms the block.
      r_armed <= 1'b1;
      r_tmo   <= w_abort;
      r_last  <= w_last_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (r_armed && w_any) begin
            r_state <= S_GRANT;
            r_gnt   <= 4'b0001 << w_pick;
            r_sel   <= w_pick;
            r_valid <= 1'b1;
            r_stall <= 8'd0;
          end
        end
        S_GRANT: begin
          if (w_done) begin
            if (w_any) begin
              r_gnt   <= 4'b0001 << w_pick;
              r_sel   <= w_pick;
              r_stall <= 8'd0;
            end else begin
              r_state <= S_IDLE;
              r_gnt   <= 4'b0000;
              r_valid <= 1'b0;
              r_stall <= 8'd0;
            end
          end else begin
            r_stall <= r_stall + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= 4'b0000;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    data_out = a_in;
    unique case (r_sel)
      2'd0: data_out = a_in;
      2'd1: data_out = b_in;
      2'd2: data_out = c_in;
      2'd3: data_out = d_in;
      default: data_out = a_in;
    endcase
  end

  assign gnt_out     = r_gnt;
  assign sel_out     = r_sel;
  assign valid_out   = r_valid;
  assign timeout_out = r_tmo;

endmodule

// File: tb/tb_rr_arb_4_way.sv
// Bench for rr_arb_4_way: directed scenarios plus a randomized run
// against a behavioural round-robin model.
module tb_rr_arb_4_way;

  localparam int DW = 32;
  localparam int T  = 4;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req;
  logic [DW-1:0] a, b, c, d;
  logic          ready;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic          valid;
  logic [DW-1:0] dout;
  logic          tmo;

  int n_run;
  int n_fail;

  rr_arb_4_way #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .req_in     (req),
    .a_in       (a),
    .b_in       (b),
    .c_in       (c),
    .d_in       (d),
    .ready_in   (ready),
    .gnt_out    (gnt),
    .sel_out    (sel),
    .valid_out  (valid),
    .data_out   (dout),
    .timeout_out(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pay(input int s);
    case (s)
      0: pay = a;
      1: pay = b;
      2: pay = c;
      default: pay = d;
    endcase
  endfunction

  function automatic int pick(input logic [3:0] r, input int last);
    pick = -1;
    for (int k = 4; k >= 1; k--)
      if (r[(last + k) % 4]) pick = (last + k) % 4;
  endfunction

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    ready = 1'b0;
    repeat (2) edge1();
    rst_n = 1'b1;
    edge1();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    ready = 1'b1;
    repeat (2) edge1();
    n_run++;
    if ({gnt, sel, valid, tmo} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_state got=%b want=0", {gnt, sel, valid, tmo});
    end
    rst_n = 1'b1;
    edge1();
    n_run++;
    if (gnt !== 4'b0000 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL release_no_grant gnt=%b valid=%b want 0000/0", gnt, valid);
    end
    edge1();
    n_run++;
    if (gnt !== 4'b0001 || sel !== 2'd0 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_grant gnt=%b sel=%0d want 0001/0", gnt, sel);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req   = 4'b1111;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edge1();
      n_run++;
      if (gnt !== exp_g[i] || valid !== 1'b1 || dout !== pay(i % 4)) begin
        n_fail++;
        $display("FAIL rotation[%0d] gnt=%b valid=%b data=%h want %b/1/%h",
                 i, gnt, valid, dout, exp_g[i], pay(i % 4));
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    req   = 4'b0100;
    ready = 1'b1;
    edge1();
    req = 4'b0000;
    n_run++;
    if (gnt !== 4'b0100 || sel !== 2'd2 || valid !== 1'b1 || dout !== c) begin
      n_fail++;
      $display("FAIL single_grant gnt=%b sel=%0d data=%h want 0100/2/%h",
               gnt, sel, dout, c);
    end
    edge1();
    n_run++;
    if (gnt !== 4'b0000 || valid !== 1'b0 || sel !== 2'd2) begin
      n_fail++;
      $display("FAIL single_idle gnt=%b valid=%b sel=%0d want 0000/0/2",
               gnt, valid, sel);
    end
  endtask

  task automatic test_timeout();
    logic exp_t;
    do_reset();
    req   = 4'b0001;
    ready = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      edge1();
      exp_t = (e >= 5) && ((e - 5) % T == 0);
      n_run++;
      if (gnt !== 4'b0001 || tmo !== exp_t) begin
        n_fail++;
        $display("FAIL timeout[%0d] gnt=%b tmo=%b want 0001/%b",
                 e, gnt, tmo, exp_t);
      end
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    req   = 4'b0010;
    ready = 1'b0;
    edge1();
    req = 4'b1000;
    edge1();
    n_run++;
    if (gnt !== 4'b1000 || tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw gnt=%b tmo=%b want 1000/0", gnt, tmo);
    end
    do_reset();
    req = 4'b0010;
    edge1();
    req = 4'b1001;
    edge1();
    n_run++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL withdraw_last gnt=%b want 0001", gnt);
    end
  endtask

  task automatic test_xfer_vs_timeout();
    do_reset();
    req   = 4'b0100;
    ready = 1'b0;
    repeat (T) edge1();
    ready = 1'b1;
    req   = 4'b0101;
    edge1();
    n_run++;
    if (tmo !== 1'b0 || gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL xfer_wins tmo=%b gnt=%b want 0/0001", tmo, gnt);
    end
    req = 4'b0000;
    edge1();
    n_run++;
    if (tmo !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL xfer_after tmo=%b valid=%b want 0/0", tmo, valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req   = 4'b1000;
    ready = 1'b0;
    edge1();
    n_run++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL pre_areset gnt=%b want 1000", gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if ({gnt, sel, valid, tmo} !== 8'b0) begin
      n_fail++;
      $display("FAIL async_reset got=%b want 0", {gnt, sel, valid, tmo});
    end
    req = 4'b1001;
    edge1();
    rst_n = 1'b1;
    edge1();
    edge1();
    n_run++;
    if (gnt !== 4'b0001 || tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL post_areset gnt=%b tmo=%b want 0001/0", gnt, tmo);
    end
  endtask

  task automatic test_random();
    int owner, last, stalls, msel;
    logic mtmo;
    logic [3:0] eg;
    do_reset();
    owner = -1;
    last  = 3;
    stalls = 0;
    msel  = 0;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) req[k] = ($urandom_range(0, 9) < 7);
      ready = $urandom_range(0, 2) == 0;
      a = $urandom; b = $urandom; c = $urandom; d = $urandom;
      mtmo = 1'b0;
      if (owner < 0) begin
        owner = pick(req, last);
        stalls = 0;
      end else if (!req[owner]) begin
        owner = pick(req, last);
        stalls = 0;
      end else if (ready) begin
        last = owner;
        owner = pick(req, last);
        stalls = 0;
      end else if (stalls + 1 == T) begin
        mtmo = 1'b1;
        last = owner;
        owner = pick(req, last);
        stalls = 0;
      end else begin
        stalls++;
      end
      if (owner >= 0) msel = owner;
      eg = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
      edge1();
      n_run++;
      if (gnt !== eg || sel !== 2'(msel) || valid !== (owner >= 0)
          || tmo !== mtmo || dout !== pay(msel)) begin
        n_fail++;
        $display("FAIL random[%0d] gnt=%b sel=%0d v=%b t=%b want %b/%0d/%b/%b",
                 i, gnt, sel, valid, tmo, eg, msel, owner >= 0, mtmo);
      end
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;
    ready  = 1'b0;
    a = 32'hA0A0_0001;
    b = 32'hB0B0_0002;
    c = 32'hC0C0_0003;
    d = 32'hD0D0_0004;
    test_reset();
    test_rotation();
    test_single();
    test_timeout();
    test_withdraw();
    test_xfer_vs_timeout();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
